// File: rtl/load_store_unit.sv
// Load/store unit between a core and a word-wide data memory; sub-word stores use read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned requests (done+err); otherwise they are force-aligned.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  wr,
  input  logic [1:0]            size,
  input  logic                  uns,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ready,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wd,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  typedef enum logic [2:0] {IDLE, LOAD, ST_RD, ST_WR, RESP} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    wr_q, wr_d;
  logic                    uns_q, uns_d;
  logic                    err_q, err_d;
  logic [1:0]              size_q, size_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   old_q, old_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic                    in_half, in_word, misal;
  logic [7:0]              ld_b;
  logic [15:0]             ld_h;
  logic [DATA_WIDTH-1:0]   ld_ext;

  assign in_half = (size == 2'b01);
  assign in_word = size[1];
  assign misal   = (in_half & addr[0]) | (in_word & (addr[1:0] != 2'b00));

  // Lane pick from the addressed word, little-endian.
  assign ld_b = mem_rd[{addr_q[1:0], 3'b000} +: 8];
  assign ld_h = mem_rd[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    if (size_q[1])      ld_ext = mem_rd;
    else if (size_q[0]) ld_ext = {{16{~uns_q & ld_h[15]}}, ld_h};
    else                ld_ext = {{24{~uns_q & ld_b[7]}}, ld_b};
  end

  // Store merge: old word with only the addressed lane(s) replaced.
  always_comb begin
    mem_wd = old_q;
    if (size_q[1])      mem_wd = wdata_q;
    else if (size_q[0]) mem_wd[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    else                mem_wd[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    uns_d   = uns_q;
    err_d   = err_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    old_d   = old_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: if (req) begin
        addr_d  = addr;
        wr_d    = wr;
        uns_d   = uns;
        size_d  = size;
        wdata_d = wdata;
        err_d   = 1'b0;
        if (!wr)         state_d = LOAD;
        else if (in_word) state_d = ST_WR;
        else             state_d = ST_RD;
`ifdef LSU_MISALIGN_TRAP_EN
        err_d = misal;
        if (misal) state_d = RESP;
`else
        // Half keeps bit 1, word clears both low bits.
        if (misal) addr_d[1:0] = addr[1:0] & {~in_word, 1'b0};
`endif
      end
      LOAD: begin
        rdata_d = ld_ext;
        state_d = RESP;
      end
      ST_RD: begin
        old_d   = mem_rd;
        state_d = ST_WR;
      end
      ST_WR:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      wdata_q <= '0;
      old_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      old_q   <= old_d;
      rdata_q <= rdata_d;
    end
  end

  assign ready    = (state_q == IDLE);
  assign done     = (state_q == RESP);
  assign err      = done & err_q;
  assign rdata    = rdata_q;
  assign mem_addr = {2'b00, addr_q[ADDR_WIDTH-1:2]};
  assign mem_we   = (state_q == ST_WR);
  assign mem_re   = (state_q == LOAD) | (state_q == ST_RD);

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random ops against a byte-lane reference model.
module tb_load_store_unit;
  logic        clk = 1'b0, rst_n = 1'b1, req = 1'b0, wr = 1'b0, uns = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0, wdata = '0;
  logic        ready, done, err, mem_we, mem_re;
  logic [31:0] rdata, mem_addr, mem_wd, mem_rd;

  logic [31:0] tb_mem [16];
  logic [31:0] ref_mem [16];
  logic [31:0] ref_rdata = '0;
  int checks = 0, errors = 0;
  int we_cnt = 0, re_cnt = 0, done_cnt = 0;
  logic [31:0] last_wd = '0, last_wa = '0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .ready(ready), .done(done), .err(err),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we),
    .mem_re(mem_re), .mem_rd(mem_rd)
  );

  assign mem_rd = tb_mem[mem_addr[3:0]];
  always @(posedge clk) if (mem_we) tb_mem[mem_addr[3:0]] <= mem_wd;

  always @(negedge clk) begin
    if (mem_we) begin
      we_cnt  <= we_cnt + 1;
      last_wd <= mem_wd;
      last_wa <= mem_addr;
    end
    if (mem_re) re_cnt <= re_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk("ready_wait", {31'd0, ready}, 32'd1);
  endtask

  // Reference: operate on whole bytes of ref_mem, then drive the DUT and compare.
  task automatic do_op(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd);
    int nb, sh, idx, lat, we0, re0, exp_lat, exp_we, exp_re;
    logic [31:0] msk, ea, v;
    logic mis, exp_err;
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    mis = (a % nb) != 0;
    ea  = a - (a % nb);
    idx = int'(ea[5:2]);
    sh  = int'(ea % 4) * 8;
    msk = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    exp_err = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    if (mis) begin
      exp_lat = 1; exp_we = 0; exp_re = 0; exp_err = 1'b1;
    end else
`endif
    if (!w) begin
      v = (ref_mem[idx] >> sh) & msk;
      if (!u && v[8 * nb - 1]) v = v | ~msk;
      ref_rdata = v;
      exp_lat = 2; exp_we = 0; exp_re = 1;
    end else begin
      ref_mem[idx] = (ref_mem[idx] & ~(msk << sh)) | ((wd & msk) << sh);
      exp_lat = (nb == 4) ? 2 : 3;
      exp_we  = 1;
      exp_re  = (nb == 4) ? 0 : 1;
    end

    wait_ready();
    req = 1'b1; wr = w; size = sz; uns = u; addr = a; wdata = wd;
    we0 = we_cnt; re0 = re_cnt;
    @(posedge clk); #1;
    lat = 1;
    while (!done && lat < 8) begin
      req = 1'($urandom_range(0, 1)); addr = $urandom; wdata = $urandom; size = 2'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    req = 1'b0;
    chk("latency", lat, exp_lat);
    chk("err", {31'd0, err}, {31'd0, exp_err});
    chk("rdata", rdata, ref_rdata);
    chk("we_count", we_cnt - we0, exp_we);
    chk("re_count", re_cnt - re0, exp_re);
    if (exp_we != 0) begin
      chk("mem_wd", last_wd, ref_mem[idx]);
      chk("mem_addr", last_wa, {2'b00, ea[31:2]});
    end
  endtask

  initial begin
    int d0, re0, nd, ncyc, acc;
    int dc [3];
    for (int i = 0; i < 16; i++) begin
      tb_mem[i]  = $urandom;
      ref_mem[i] = tb_mem[i];
    end
    #1 rst_n = 1'b0;
    #2;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_we_re", {30'd0, mem_we, mem_re}, 32'd0);
    chk("rst_maddr", mem_addr, 32'd0);
    chk("rst_mwd", mem_wd, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    do_op(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    chk("wst_wd", last_wd, 32'hDEADBEEF);
    chk("wst_wa", last_wa, 32'h4);
    do_op(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344);
    do_op(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AA);
    chk("rmw_wd", last_wd, 32'h1122AA44);
    do_op(1'b1, 2'd2, 1'b0, 32'h10, 32'h0000F080);
    do_op(1'b0, 2'd1, 1'b0, 32'h10, 32'h0);
    chk("lh_signed", rdata, 32'hFFFFF080);
    do_op(1'b0, 2'd1, 1'b1, 32'h10, 32'h0);
    chk("lh_unsigned", rdata, 32'h0000F080);
    do_op(1'b0, 2'd0, 1'b0, 32'h11, 32'h0);
    chk("lb_signed", rdata, 32'hFFFFFFF0);
    do_op(1'b0, 2'd2, 1'b0, 32'h12, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_rdata_kept", rdata, 32'hFFFFFFF0);
`else
    chk("mis_aligned_ld", rdata, 32'h0000F080);
`endif

    // Reset while in ST_WR: write must not land, no done pulse.
    wait_ready();
    req = 1'b1; wr = 1'b1; size = 2'd0; uns = 1'b0; addr = 32'h24; wdata = $urandom;
    d0 = done_cnt;
    @(posedge clk); #1 req = 1'b0;
    @(posedge clk); #1;
    chk("stwr_we", {31'd0, mem_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rr_we", {31'd0, mem_we}, 32'd0);
    chk("rr_ready", {31'd0, ready}, 32'd1);
    chk("rr_done", {31'd0, done}, 32'd0);
    chk("rr_maddr", mem_addr, 32'd0);
    chk("rr_mwd", mem_wd, 32'd0);
    chk("rr_rdata", rdata, 32'd0);
    ref_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("rr_mem", tb_mem[9], ref_mem[9]);
    chk("rr_no_done", done_cnt - d0, 32'd0);
    chk("rr_ready_after", {31'd0, ready}, 32'd1);

    // Back-to-back word loads with req held; junk req while busy.
    @(posedge clk); #1;
    d0 = done_cnt; re0 = re_cnt; nd = 0; ncyc = 0; acc = 0;
    wr = 1'b0; size = 2'd2; uns = 1'b0; addr = 32'h20;
    while (nd < 3 && ncyc < 40) begin
      @(negedge clk);
      ncyc++;
      if (done) begin
        dc[nd] = ncyc;
        nd++;
      end
      if (ready) begin
        req = (acc < 3);
        if (acc < 3) acc++;
      end else req = 1'($urandom_range(0, 1));
    end
    req = 1'b0;
    repeat (6) @(negedge clk);
    chk("b2b_dones", nd, 32'd3);
    chk("b2b_space1", dc[1] - dc[0], 32'd3);
    chk("b2b_space2", dc[2] - dc[1], 32'd3);
    chk("b2b_total_done", done_cnt - d0, 32'd3);
    chk("b2b_reads", re_cnt - re0, 32'd3);
    chk("b2b_rdata", rdata, ref_mem[8]);
    ref_rdata = ref_mem[8];

    for (int k = 0; k < 80; k++)
      do_op(1'($urandom_range(0, 1)), 2'($urandom), 1'($urandom_range(0, 1)),
            32'($urandom_range(0, 63)), $urandom);
    for (int i = 0; i < 16; i++) chk("final_mem", tb_mem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
